// File: rtl/const_div_seq.sv
// Sequential unsigned divider by a compile-time constant D. It retires K dividend bits
// per cycle, MSB first, and has valid/ready handshakes on the operand and result sides.
module const_div_seq #(
  parameter int W = 64,
  parameter int D = 11,
  parameter int K = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_quot,
  output logic [$clog2(D)-1:0] out_rem,
  output logic                 busy
);

  localparam int R = $clog2(D);
  localparam int STEPS = W / K;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [R:0] DIV = (R+1)'(D);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (K < 1 || K > 8 || (W % K) != 0 || D < 2 || D >= 65536) begin : g_badParams
    $error("const_div_seq: illegal parameters W=%0d D=%0d K=%0d", W, D, K);
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     workReg_q, workReg_d;
  logic [R-1:0]     rem_q, rem_d;
  logic [CW-1:0]    count_q, count_d;
  logic [W-1:0]     outQuot_q, outQuot_d;
  logic [R-1:0]     outRem_q, outRem_d;

  logic [R:0]       acc;
  logic [K-1:0]     qChunk;
  logic [R-1:0]     remNext;
  logic [W-1:0]     workNext;
  logic             accept;

  // The dividend leaves the top of workReg while quotient digits enter at the bottom,
  // so after STEPS shifts the register holds the full quotient.
  always_comb begin
    acc = {1'b0, rem_q};
    qChunk = '0;
    for (int j = K - 1; j >= 0; j--) begin
      acc = {acc[R-1:0], workReg_q[W-K+j]};
      if (acc >= DIV) begin
        acc = acc - DIV;
        qChunk[j] = 1'b1;
      end
    end
    remNext = acc[R-1:0];
    workNext = (workReg_q << K) | W'(qChunk);
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign out_quot  = outQuot_q;
  assign out_rem   = outRem_q;

  always_comb begin
    state_d   = state_q;
    workReg_d = workReg_q;
    rem_d     = rem_q;
    count_d   = count_q;
    outQuot_d = outQuot_q;
    outRem_d  = outRem_q;
    case (state_q)
      IDLE: ;
      RUN: begin
        workReg_d = workNext;
        rem_d     = remNext;
        count_d   = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d   = DONE;
          outQuot_d = workNext;
          outRem_d  = remNext;
        end
      end
      DONE: begin
        if (out_ready && !in_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // An accept in DONE overrides the return to IDLE, giving back-to-back operation.
    if (accept) begin
      workReg_d = in_data;
      rem_d     = '0;
      count_d   = '0;
      state_d   = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      workReg_q <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      outQuot_q <= '0;
      outRem_q  <= '0;
    end else begin
      state_q   <= state_d;
      workReg_q <= workReg_d;
      rem_q     <= rem_d;
      count_q   <= count_d;
      outQuot_q <= outQuot_d;
      outRem_q  <= outRem_d;
    end
  end

endmodule
